arb_mux2s1: RTL and testbench

Registered two-input stream selector with round-robin arbitration. It generates the select for a 2:1 data mux from two valid/ready requesters, latches the winning word into a single output register, and presents it downstream with a valid/ready handshake. It also keeps per-input saturating grant counters for debug. It sits directly upstream of the downstream consumer and replaces free-running select logic wherever both mux inputs can carry traffic at the same time.

---
 rtl/arb_mux2s1.sv | 149 ++++++++++++++
 tb/tb_arb_mux2s1.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux2s1.sv
// ---------------------------------------------------------------------------
// arb_mux2s1
//
// Registered two-input stream selector with round-robin arbitration.
// Two valid/ready requesters (a = input 0, b = input 1) compete for a single
// output register. The winning word is latched and presented downstream on a
// valid/ready handshake. Per-input saturating grant counters are kept for
// debug.
//
// Handshake: a word moves across an interface on a rising clock edge exactly
// when its valid and ready are both 1 in the cycle before that edge. In this
// block ready is derived combinationally from the valids and y_ready.
// Upstream must therefore never make its valid depend on its ready.
//
// Parameters:
//   W   data width of a_data, b_data and y_data
//   CW  width of the grant counters
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   a_valid  input 0 has a word
//   a_data   input 0 word
//   a_ready  input 0 word accepted this cycle
//   b_valid  input 1 has a word
//   b_data   input 1 word
//   b_ready  input 1 word accepted this cycle
//   y_valid  output register holds a word
//   y_data   output word
//   y_src    source of y_data (0 = a, 1 = b)
//   y_ready  downstream accepts y_data
//   clr      synchronous clear of both grant counters
//   cnt_a    saturating count of words accepted from a
//   cnt_b    saturating count of words accepted from b
// ---------------------------------------------------------------------------
module arb_mux2s1 #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic [W-1:0]  a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [W-1:0]  b_data,
    output logic          b_ready,
    output logic          y_valid,
    output logic [W-1:0]  y_data,
    output logic          y_src,
    input  logic          y_ready,
    input  logic          clr,
    output logic [CW-1:0] cnt_a,
    output logic [CW-1:0] cnt_b
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          y_valid_q, y_valid_d;
    logic [W-1:0]  y_data_q,  y_data_d;
    logic          y_src_q,   y_src_d;
    logic          last_q,    last_d;
    logic [CW-1:0] cnt_a_q,   cnt_a_d;
    logic [CW-1:0] cnt_b_q,   cnt_b_d;

    logic acc;
    logic grant_a;
    logic grant_b;

    // Arbitration. The register can take a word when it is empty or is being
    // drained in this same cycle. On contention the input that did not win
    // last time is served; last_q resets to b so a wins first.
    always_comb begin
        acc     = !y_valid_q || y_ready;
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (acc) begin
            if (a_valid && (!b_valid || last_q)) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a_ready = acc && grant_a;
    assign b_ready = acc && grant_b;

    // Output register and round-robin pointer.
    always_comb begin
        y_valid_d = y_valid_q;
        y_data_d  = y_data_q;
        y_src_d   = y_src_q;
        last_d    = last_q;
        if (grant_a || grant_b) begin
            y_valid_d = 1'b1;
            y_data_d  = grant_b ? b_data : a_data;
            y_src_d   = grant_b;
            last_d    = grant_b;
        end else if (acc) begin
            // Drained (or already empty) with nothing to refill; data and
            // source are left as they were.
            y_valid_d = 1'b0;
        end
    end

    // Grant counters: clear beats increment, increment stops at all-ones.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (clr) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
        end else begin
            if (a_valid && a_ready && (cnt_a_q != CNT_MAX)) begin
                cnt_a_d = cnt_a_q + CNT_ONE;
            end
            if (b_valid && b_ready && (cnt_b_q != CNT_MAX)) begin
                cnt_b_d = cnt_b_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            y_src_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
        end else begin
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
            y_src_q   <= y_src_d;
            last_q    <= last_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
        end
    end

    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign y_src   = y_src_q;
    assign cnt_a   = cnt_a_q;
    assign cnt_b   = cnt_b_q;

endmodule

// File: tb/tb_arb_mux2s1.sv
// ---------------------------------------------------------------------------
// tb_arb_mux2s1
//
// Directed bench for arb_mux2s1 (W = 8, CW = 4) followed by a randomized
// phase checked against a small reference model and per-source expected
// queues. Inputs change 1 ns after the rising edge; outputs are sampled 1 ns
// later.
// ---------------------------------------------------------------------------
module tb_arb_mux2s1;

    localparam int W  = 8;
    localparam int CW = 4;

    // ---------------- clock / reset ----------------
    logic          clk;
    logic          rst_n;
    logic          a_valid, b_valid, y_ready, clr;
    logic [W-1:0]  a_data, b_data;
    logic          a_ready, b_ready, y_valid, y_src;
    logic [W-1:0]  y_data;
    logic [CW-1:0] cnt_a, cnt_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    arb_mux2s1 #(.W(W), .CW(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_src   (y_src),
        .y_ready (y_ready),
        .clr     (clr),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b)
    );

    // ---------------- bookkeeping ----------------
    int tests_run;
    int tests_failed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic av, input logic [W-1:0] ad,
                          input logic bv, input logic [W-1:0] bd,
                          input logic yr);
        a_valid = av;
        a_data  = ad;
        b_valid = bv;
        b_data  = bd;
        y_ready = yr;
    endtask

    // ---------------- scoreboard state ----------------
    logic [W-1:0]  exp_qa[$];
    logic [W-1:0]  exp_qb[$];
    logic [W-1:0]  exp_word;
    logic          last_m;
    logic [CW-1:0] cnt_a_m, cnt_b_m;
    logic          acc_m, ga_m, gb_m;
    int            skip_a, skip_b;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clr          = 1'b0;
        set_in(1'b0, '0, 1'b0, '0, 1'b0);

        // ---------- reset values ----------
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_y_valid", y_valid, 0);
        check("rst_y_data",  y_data,  0);
        check("rst_y_src",   y_src,   0);
        check("rst_cnt_a",   cnt_a,   0);
        check("rst_cnt_b",   cnt_b,   0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------- contention: a first, then strict alternation ----------
        begin
            logic [W-1:0] ai;
            logic [W-1:0] bi;
            ai = 8'hA0;
            bi = 8'hB0;
            for (int k = 0; k < 6; k++) begin
                set_in(1'b1, ai, 1'b1, bi, 1'b1);
                #1;
                check("cont_a_ready", a_ready, (k % 2 == 0) ? 1 : 0);
                check("cont_b_ready", b_ready, (k % 2 == 1) ? 1 : 0);
                tick();
                check("cont_y_valid", y_valid, 1);
                if (k % 2 == 0) begin
                    check("cont_y_data", y_data, ai);
                    check("cont_y_src",  y_src,  0);
                    ai = ai + 8'd1;
                end else begin
                    check("cont_y_data", y_data, bi);
                    check("cont_y_src",  y_src,  1);
                    bi = bi + 8'd1;
                end
            end
        end
        check("cont_cnt_a", cnt_a, 3);
        check("cont_cnt_b", cnt_b, 3);
        set_in(1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        check("cont_drain_valid", y_valid, 0);
        check("cont_drain_hold",  y_data,  8'hB2);

        // ---------- clear, then single source a ----------
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_cnt_a", cnt_a, 0);
        check("clr_cnt_b", cnt_b, 0);
        set_in(1'b1, 8'h11, 1'b0, '0, 1'b1);
        #1;
        check("single_a_ready", a_ready, 1);
        check("single_b_ready", b_ready, 0);
        tick();
        check("single_d0", y_data, 8'h11);
        check("single_s0", y_src,  0);
        a_data = 8'h22;
        tick();
        check("single_d1", y_data, 8'h22);
        a_data = 8'h33;
        tick();
        check("single_d2", y_data,  8'h33);
        check("single_v2", y_valid, 1);
        check("single_cnt_a", cnt_a, 3);
        check("single_cnt_b", cnt_b, 0);
        a_valid = 1'b0;
        tick();
        check("single_idle_valid", y_valid, 0);

        // ---------- backpressure ----------
        set_in(1'b1, 8'h5A, 1'b0, '0, 1'b1);
        tick();
        check("bp_load", y_data, 8'h5A);
        set_in(1'b1, 8'h66, 1'b1, 8'h77, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_a_ready", a_ready, 0);
            check("bp_b_ready", b_ready, 0);
            tick();
            check("bp_y_valid", y_valid, 1);
            check("bp_y_data",  y_data,  8'h5A);
            check("bp_cnt_a",   cnt_a,   4);
            check("bp_cnt_b",   cnt_b,   0);
        end
        // last grant was a, so b wins once the register drains
        y_ready = 1'b1;
        #1;
        check("bp_rel_a_ready", a_ready, 0);
        check("bp_rel_b_ready", b_ready, 1);
        tick();
        check("bp_rel_data", y_data, 8'h77);
        check("bp_rel_src",  y_src,  1);
        b_valid = 1'b0;
        tick();
        check("bp_rel_data2", y_data, 8'h66);
        set_in(1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        check("bp_cnt_a_end", cnt_a, 5);
        check("bp_cnt_b_end", cnt_b, 1);

        // ---------- saturation and clear ----------
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 20; k++) begin
            set_in(1'b0, '0, 1'b1, 8'(k), 1'b1);
            tick();
        end
        check("sat_cnt_b", cnt_b, 15);
        check("sat_data",  y_data, 8'd19);
        check("sat_src",   y_src,  1);
        b_data = 8'd20;
        tick();
        check("sat_hold", cnt_b, 15);
        b_data = 8'd21;
        clr    = 1'b1;
        tick();
        clr = 1'b0;
        check("sat_clr_cnt_b", cnt_b, 0);
        check("sat_clr_data",  y_data, 8'd21);

        // ---------- reset mid-transfer ----------
        set_in(1'b1, 8'h3C, 1'b0, '0, 1'b0);
        tick();
        check("mid_loaded", y_valid, 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", y_valid, 0);
        check("mid_rst_data",  y_data,  0);
        check("mid_rst_src",   y_src,   0);
        check("mid_rst_cnt_a", cnt_a,   0);
        check("mid_rst_cnt_b", cnt_b,   0);
        set_in(1'b1, 8'hC1, 1'b1, 8'hC2, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_data", y_data, 8'hC1);
        check("post_rst_src",  y_src,  0);
        check("post_rst_cnt_a", cnt_a, 1);

        // ---------- random phase against the model ----------
        set_in(1'b0, '0, 1'b0, '0, 1'b1);
        clr = 1'b1;
        tick();
        clr     = 1'b0;
        last_m  = 1'b0;
        cnt_a_m = '0;
        cnt_b_m = '0;
        skip_a  = 0;
        skip_b  = 0;
        for (int n = 0; n < 400; n++) begin
            set_in(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 3) != 0));
            #1;
            acc_m = !(exp_qa.size() + exp_qb.size() != 0) || y_ready;
            ga_m  = acc_m && a_valid && (!b_valid || last_m);
            gb_m  = acc_m && b_valid && !ga_m;
            check("rnd_y_valid", y_valid, (exp_qa.size() + exp_qb.size() != 0) ? 1 : 0);
            check("rnd_a_ready", a_ready, ga_m);
            check("rnd_b_ready", b_ready, gb_m);
            check("rnd_cnt_a",   cnt_a,   cnt_a_m);
            check("rnd_cnt_b",   cnt_b,   cnt_b_m);
            // drain before refill
            if (y_valid && y_ready) begin
                if (y_src == 1'b0) begin
                    check("rnd_qa_nonempty", (exp_qa.size() != 0) ? 1 : 0, 1);
                    if (exp_qa.size() != 0) begin
                        exp_word = exp_qa.pop_front();
                        check("rnd_data_a", y_data, exp_word);
                    end
                end else begin
                    check("rnd_qb_nonempty", (exp_qb.size() != 0) ? 1 : 0, 1);
                    if (exp_qb.size() != 0) begin
                        exp_word = exp_qb.pop_front();
                        check("rnd_data_b", y_data, exp_word);
                    end
                end
            end
            // starvation: a waiting input loses at most one grant
            if (a_valid && b_ready) skip_a++;
            if (a_ready) skip_a = 0;
            if (!a_valid) skip_a = 0;
            if (b_valid && a_ready) skip_b++;
            if (b_ready) skip_b = 0;
            if (!b_valid) skip_b = 0;
            check("rnd_skip_a", (skip_a <= 1) ? 1 : 0, 1);
            check("rnd_skip_b", (skip_b <= 1) ? 1 : 0, 1);
            if (ga_m) begin
                exp_qa.push_back(a_data);
                last_m = 1'b0;
                if (cnt_a_m != '1) cnt_a_m = cnt_a_m + 1'b1;
            end
            if (gb_m) begin
                exp_qb.push_back(b_data);
                last_m = 1'b1;
                if (cnt_b_m != '1) cnt_b_m = cnt_b_m + 1'b1;
            end
            tick();
        end
        // final drain
        set_in(1'b0, '0, 1'b0, '0, 1'b1);
        #1;
        if (y_valid) begin
            if (y_src == 1'b0 && exp_qa.size() != 0) begin
                exp_word = exp_qa.pop_front();
                check("end_data_a", y_data, exp_word);
            end else if (y_src == 1'b1 && exp_qb.size() != 0) begin
                exp_word = exp_qb.pop_front();
                check("end_data_b", y_data, exp_word);
            end
        end
        tick();
        check("end_y_valid", y_valid, 0);
        check("end_qa_empty", exp_qa.size(), 0);
        check("end_qb_empty", exp_qb.size(), 0);

        // ---------- report ----------
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
